gb_oam_dma_ctrl: RTL and testbench

GB_OAM_DMA_CTRL -- requirements
Module: gb_oam_dma_ctrl

---
 rtl/gb_dma_pkg.sv | 40 ++++
 rtl/gb_oam_dma_ctrl.sv | 178 +++++++++++++++++
 tb/tb_gb_oam_dma_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_dma_pkg.sv
// ---------------------------------------------------------------------------
// gb_dma_pkg
// Shared constants, state/phase encodings and address decode helpers for the
// Game Boy OAM DMA controller (gb_oam_dma_ctrl).
// ---------------------------------------------------------------------------
package gb_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int unsigned DMA_LEN      = 160;
    localparam int unsigned START_CLKS   = 4;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } dma_state_t;

    // One OAM byte takes four clocks: read, wait, write, wait.
    typedef enum logic [1:0] {
        P0,
        P1,
        P2,
        P3
    } dma_phase_t;

    // Source of cpu_rdata for the clock after a CPU read.
    typedef enum logic [1:0] {
        RD_SRC,
        RD_FF,
        RD_MEM
    } rd_sel_t;

    function automatic logic is_hram(input logic [15:0] addr);
        return (addr >= HRAM_LO) && (addr <= HRAM_HI);
    endfunction

endpackage

// File: rtl/gb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// gb_oam_dma_ctrl
// OAM DMA engine sitting between gb_cpu and the shared memory bus. A write to
// 0xFF46 latches the source page and, after a 4-clock start-up delay, copies
// 160 bytes from {src_hi, 0x00..0x9F} into OAM (0xFE00..0xFE9F), one byte per
// four clocks. While the engine is active only HRAM is reachable by the CPU.
//
// Ports
//   clock                  CPU clock
//   rst                    asynchronous reset, active low
//   cpu_addr/wdata/we/re   single-clock CPU access strobes
//   cpu_rdata              CPU read data, valid the clock after cpu_re
//   mem_addr/wdata/we/re   shared memory bus request
//   mem_rdata              bus read data, valid the clock after mem_re
//   dma_active             high during start-up delay and transfer
// ---------------------------------------------------------------------------
module gb_oam_dma_ctrl
    import gb_dma_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [1:0] START_LAST = 2'(START_CLKS - 1);

    dma_state_t state;
    dma_phase_t phase;
    rd_sel_t    rd_sel;
    logic [7:0] byte_idx;
    logic [7:0] dma_src;
    logic [7:0] byte_latch;
    logic       rd_pending;

    logic       cpu_access;
    logic       hram_hit;
    logic       reg_hit;
    logic       reg_write;
    logic       stall;
    logic [7:0] src_hi;
    logic       dma_rd;
    logic       dma_wr;

    assign cpu_access = cpu_we | cpu_re;
    assign hram_hit   = cpu_access & is_hram(cpu_addr);
    assign reg_hit    = (cpu_addr == DMA_REG_ADDR);
    assign reg_write  = cpu_we & reg_hit;

    // An HRAM access takes the bus for its clock and freezes the engine.
    assign stall      = dma_active & hram_hit;

    // Pages 0xE0 and up are echo RAM; fold them back onto work RAM.
    assign src_hi     = (dma_src < 8'hE0) ? dma_src : (dma_src - 8'h20);

    // A restart write suppresses the engine's strobe in its own clock so the
    // half-finished byte is simply abandoned.
    assign dma_rd = (state == XFER) && (phase == P0) && !stall && !reg_write;
    assign dma_wr = (state == XFER) && (phase == P2) && !stall && !reg_write;

    // Bus mux. Reset forces the strobes low so nothing escapes while rst is
    // held, even if the CPU is still strobing. CPU writes win over a (bogus)
    // simultaneous read so we and re are never both driven.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (!rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end else if (dma_active) begin
            if (hram_hit) begin
                mem_we = cpu_we;
                mem_re = cpu_re & ~cpu_we;
            end else if (dma_rd) begin
                mem_addr = {src_hi, byte_idx};
                mem_re   = 1'b1;
            end else if (dma_wr) begin
                mem_addr  = OAM_BASE + {8'h00, byte_idx};
                mem_wdata = byte_latch;
                mem_we    = 1'b1;
            end
        end else if (!reg_hit) begin
            mem_we = cpu_we;
            mem_re = cpu_re & ~cpu_we;
        end
    end

    // Read return: the source is chosen when the read is issued, the data
    // itself is presented the following clock.
    always_comb begin
        case (rd_sel)
            RD_SRC:  cpu_rdata = dma_src;
            RD_FF:   cpu_rdata = 8'hFF;
            default: cpu_rdata = mem_rdata;
        endcase
    end

    // Engine FSM. The phase counter doubles as the start-up delay counter, so
    // START lasts exactly one P0..P3 sweep.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= P0;
            byte_idx   <= 8'h00;
            dma_src    <= 8'h00;
            dma_active <= 1'b0;
            byte_latch <= 8'h00;
            rd_pending <= 1'b0;
            rd_sel     <= RD_SRC;
        end else begin
            rd_pending <= dma_rd;
            if (rd_pending) begin
                byte_latch <= mem_rdata;
            end

            if (cpu_re) begin
                if (reg_hit) begin
                    rd_sel <= RD_SRC;
                end else if (dma_active && !hram_hit) begin
                    rd_sel <= RD_FF;
                end else begin
                    rd_sel <= RD_MEM;
                end
            end

            if (reg_write) begin
                dma_src    <= cpu_wdata;
                state      <= START;
                phase      <= P0;
                byte_idx   <= 8'h00;
                dma_active <= 1'b1;
            end else if (dma_active && !stall) begin
                case (state)
                    START: begin
                        if (phase == START_LAST) begin
                            state <= XFER;
                            phase <= P0;
                        end else begin
                            phase <= dma_phase_t'(phase + 2'd1);
                        end
                    end
                    XFER: begin
                        if (phase == P3) begin
                            phase <= P0;
                            if (byte_idx == LAST_IDX) begin
                                state      <= IDLE;
                                byte_idx   <= 8'h00;
                                dma_active <= 1'b0;
                            end else begin
                                byte_idx <= byte_idx + 8'd1;
                            end
                        end else begin
                            phase <= dma_phase_t'(phase + 2'd1);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        phase      <= P0;
                        dma_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gb_oam_dma_ctrl
// Self-checking bench for gb_oam_dma_ctrl. A simple memory slave answers the
// mem_* bus; a reference image of memory is kept separately and OAM contents
// and transfer lengths are predicted from the architectural rules.
// ---------------------------------------------------------------------------
module tb_gb_oam_dma_ctrl;

    logic        clock;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    logic [7:0] mem     [0:65535];
    logic [7:0] exp_mem [0:65535];

    int checks = 0;
    int errors = 0;
    int total_active = 0;
    int both_strobes = 0;
    int reset_strobes = 0;

    gb_oam_dma_ctrl dut (
        .clock      (clock),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory slave: synchronous write, read data one clock after mem_re.
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Bus observers sampled mid-cycle.
    always @(negedge clock) begin
        if (dma_active === 1'b1) total_active <= total_active + 1;
        if (mem_we === 1'b1 && mem_re === 1'b1) both_strobes <= both_strobes + 1;
        if (rst === 1'b0 && (mem_we !== 1'b0 || mem_re !== 1'b0)) reset_strobes <= reset_strobes + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    // Source page seen by the engine: echo RAM folds down by 0x20 pages.
    function automatic logic [7:0] src_page(input logic [7:0] s);
        return (s < 8'hE0) ? s : 8'(s - 8'h20);
    endfunction

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_re   = 1'b1;
        tick();
        cpu_re   = 1'b0;
        d        = cpu_rdata;
    endtask

    task automatic preload(input logic [7:0] page, input bit pattern);
        logic [7:0] d;
        for (int i = 0; i < 160; i++) begin
            d = pattern ? (8'(i) ^ 8'h3C) : 8'($urandom);
            cpu_write({page, 8'(i)}, d);
            exp_mem[{page, 8'(i)}] = d;
        end
    endtask

    // Issues the FF46 write; returns with the bench in clock 1 of the DMA.
    task automatic applyStimulus(input logic [7:0] src, output int snap);
        snap      = total_active;
        cpu_addr  = 16'hFF46;
        cpu_wdata = src;
        cpu_we    = 1'b1;
        #1;
        check("ff46_not_on_bus", {31'd0, mem_we}, 32'd0);
        tick();
        cpu_we = 1'b0;
        check("active_after_ff46", {31'd0, dma_active}, 32'd1);
    endtask

    // Waits for the transfer to finish, then checks its length and OAM.
    task automatic checkOutput(input logic [7:0] src, input int snap, input int exp_len);
        int g;
        logic [7:0] pg;
        g = 0;
        while (dma_active === 1'b1 && g < 4000) begin
            tick();
            g++;
        end
        check("dma_done_in_bound", {31'd0, dma_active}, 32'd0);
        check("active_clocks", 32'(total_active - snap), 32'(exp_len));
        pg = src_page(src);
        for (int i = 0; i < 160; i++) begin
            exp_mem[16'hFE00 + i] = exp_mem[{pg, 8'(i)}];
            check($sformatf("oam[%0d]", i), {24'd0, mem[16'hFE00 + i]}, {24'd0, exp_mem[16'hFE00 + i]});
        end
    endtask

    initial begin
        int snap;
        int k;
        int rc;
        logic [7:0] rd;
        logic [7:0] rp;

        rst       = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;

        // Reset state, with the CPU strobing a read to prove it is gated.
        tick_n(3);
        cpu_addr = 16'hC000;
        cpu_re   = 1'b1;
        #1;
        check("rst_dma_active", {31'd0, dma_active}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        tick();
        cpu_re = 1'b0;
        rst    = 1'b1;
        tick();

        // Idle pass-through write and read back.
        cpu_addr  = 16'hC123;
        cpu_wdata = 8'h5A;
        cpu_we    = 1'b1;
        #1;
        check("pt_mem_we", {31'd0, mem_we}, 32'd1);
        check("pt_mem_re", {31'd0, mem_re}, 32'd0);
        check("pt_mem_addr", {16'd0, mem_addr}, 32'h0000C123);
        check("pt_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
        tick();
        cpu_we = 1'b0;
        exp_mem[16'hC123] = 8'h5A;
        cpu_read(16'hC123, rd);
        check("pt_read", {24'd0, rd}, 32'h5A);
        cpu_read(16'hFF46, rd);
        check("ff46_after_reset", {24'd0, rd}, 32'h00);

        // Source data.
        rp = 8'(32'hD5 + $urandom_range(0, 10));
        preload(8'hC0, 1'b1);
        preload(8'hD0, 1'b0);
        preload(8'hC1, 1'b0);
        preload(rp, 1'b0);

        // Full transfer, no interference.
        applyStimulus(8'hC0, snap);
        checkOutput(8'hC0, snap, 644);

        // HRAM write in a P0 clock of a random byte.
        k = $urandom_range(0, 159);
        applyStimulus(rp, snap);
        tick_n(4 + 4 * k);
        cpu_addr  = 16'hFF90;
        cpu_wdata = 8'h77;
        cpu_we    = 1'b1;
        #1;
        check("hram_mem_we", {31'd0, mem_we}, 32'd1);
        check("hram_mem_re", {31'd0, mem_re}, 32'd0);
        check("hram_mem_addr", {16'd0, mem_addr}, 32'h0000FF90);
        check("hram_mem_wdata", {24'd0, mem_wdata}, 32'h77);
        tick();
        cpu_we = 1'b0;
        exp_mem[16'hFF90] = 8'h77;
        checkOutput(rp, snap, 645);
        check("hram_stored", {24'd0, mem[16'hFF90]}, {24'd0, exp_mem[16'hFF90]});
        cpu_read(16'hFF90, rd);
        check("hram_readback", {24'd0, rd}, 32'h77);

        // Blocked accesses while active.
        applyStimulus(8'hC0, snap);
        tick_n($urandom_range(10, 100));
        cpu_read(16'hC000, rd);
        check("blocked_read", {24'd0, rd}, 32'hFF);
        cpu_read(16'hFF46, rd);
        check("ff46_read_active", {24'd0, rd}, 32'hC0);
        cpu_addr  = 16'hD000;
        cpu_wdata = ~exp_mem[16'hD000];
        cpu_we    = 1'b1;
        #1;
        check("blocked_write_strobe", {31'd0, (mem_we === 1'b1 && mem_addr === 16'hD000)}, 32'd0);
        tick();
        cpu_we = 1'b0;
        checkOutput(8'hC0, snap, 644);
        check("blocked_write_mem", {24'd0, mem[16'hD000]}, {24'd0, exp_mem[16'hD000]});

        // Restart at byte 50 (its P1 clock).
        rc = 5 + 4 * 50 + 1;
        applyStimulus(8'hC0, snap);
        tick_n(rc - 1);
        cpu_write(16'hFF46, 8'hD0);
        checkOutput(8'hD0, snap, rc + 644);
        cpu_read(16'hFF46, rd);
        check("ff46_after_restart", {24'd0, rd}, 32'hD0);

        // Reset in the P0 clock of byte 80.
        applyStimulus(rp, snap);
        tick_n(4 + 4 * 80);
        rst      = 1'b0;
        cpu_addr = 16'hC000;
        cpu_re   = 1'b1;
        #1;
        check("midrst_dma_active", {31'd0, dma_active}, 32'd0);
        check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrst_mem_re", {31'd0, mem_re}, 32'd0);
        check("midrst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        tick_n(3);
        cpu_re = 1'b0;
        rst    = 1'b1;
        tick_n(2);
        check("post_rst_idle", {31'd0, dma_active}, 32'd0);
        check("reset_strobes", 32'(reset_strobes), 32'd0);
        cpu_read(16'hFF46, rd);
        check("ff46_after_midrst", {24'd0, rd}, 32'h00);

        // Echo source page.
        applyStimulus(8'hE1, snap);
        checkOutput(8'hE1, snap, 644);
        cpu_read(16'hFF46, rd);
        check("ff46_echo", {24'd0, rd}, 32'hE1);

        check("we_re_never_together", 32'(both_strobes), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
